// File: rtl/bsn_pkg.sv
// Shared types and stage-mask helper for the barrel-shift normalizer.
package bsn_pkg;

  localparam int unsigned BSN_MAX_W = 256;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // Bits examined by stage k: the top 2^k bits (left) or bottom 2^k bits (right) of a w-bit word.
  function automatic logic [BSN_MAX_W-1:0] stage_mask(input int unsigned w,
                                                      input int unsigned k,
                                                      input logic right);
    logic [BSN_MAX_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < BSN_MAX_W; i++) begin
      if (right) m[i] = (i < (32'd1 << k));
      else       m[i] = (i < w) && ((i + (32'd1 << k)) >= w);
    end
    return m;
  endfunction

endpackage

// File: rtl/bsn_step.sv
// One combinational binary-search stage: shifts by 2^k when the examined 2^k bits are all zero.
module bsn_step
  import bsn_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter logic        P_RIGHT = 1'b0,
  parameter int unsigned SHIFT_W = $clog2(W)
) (
  input  logic [W-1:0]       val_i,
  input  logic [SHIFT_W-1:0] k_i,
  output logic [W-1:0]       val_o,
  output logic               hit_o
);

  logic [BSN_MAX_W-1:0] mask_full;
  int unsigned          amt;

  always_comb begin
    mask_full = stage_mask(W, 32'(k_i), P_RIGHT);
    amt       = 32'd1 << k_i;
    hit_o     = ((val_i & mask_full[W-1:0]) == '0);
    val_o     = val_i;
    if (hit_o) val_o = P_RIGHT ? (val_i >> amt) : (val_i << amt);
  end

endmodule

// File: rtl/bsn.sv
// Sequential normalizer: result SHIFT_W cycles after accept, held until out_rdy_i.
// BSN_B2B_EN lets a pop and a new accept share one cycle; otherwise one idle cycle separates results.
module bsn
  import bsn_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter logic        P_RIGHT = 1'b0,
  parameter int unsigned SHIFT_W = $clog2(W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld_i,
  output logic               in_rdy_o,
  input  logic [W-1:0]       x_i,
  output logic               out_vld_o,
  input  logic               out_rdy_i,
  output logic [W-1:0]       y_o,
  output logic [SHIFT_W-1:0] shift_o,
  output logic               zero_o
);

  if (W < 2 || (W & (W - 1)) != 0 || W > BSN_MAX_W) begin : g_bad_w
    $error("bsn: W must be a power of two between 2 and BSN_MAX_W");
  end

  localparam logic [SHIFT_W-1:0] K_TOP = SHIFT_W'(SHIFT_W - 1);

  state_e               state_q, state_d;
  logic [W-1:0]         y_q, y_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [SHIFT_W-1:0]   k_q, k_d;
  logic                 zero_q, zero_d;
  logic                 in_rdy_q, in_rdy_d;
  logic                 out_vld_q, out_vld_d;
  logic                 load;
  logic [W-1:0]         step_val;
  logic                 step_hit;

  // y_q doubles as the working register; its contents only matter once out_vld_o is set.
  bsn_step #(.W(W), .P_RIGHT(P_RIGHT), .SHIFT_W(SHIFT_W)) u_step (
    .val_i (y_q),
    .k_i   (k_q),
    .val_o (step_val),
    .hit_o (step_hit)
  );

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    shift_d   = shift_q;
    k_d       = k_q;
    zero_d    = zero_q;
    in_rdy_d  = in_rdy_q;
    out_vld_d = out_vld_q;
    load      = 1'b0;
    unique case (state_q)
      IDLE: load = in_vld_i;
      BUSY: begin
        y_d          = step_val;
        shift_d[k_q] = step_hit;
        if (k_q == '0) begin
          state_d   = DONE;
          out_vld_d = 1'b1;
          zero_d    = (step_val == '0);
        end else begin
          k_d = k_q - SHIFT_W'(1);
        end
      end
      DONE: begin
        if (out_rdy_i) begin
          out_vld_d = 1'b0;
          state_d   = IDLE;
          in_rdy_d  = 1'b1;
`ifdef BSN_B2B_EN
          load      = in_vld_i;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      y_d      = x_i;
      shift_d  = '0;
      k_d      = K_TOP;
      state_d  = BUSY;
      in_rdy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      y_q       <= '0;
      shift_q   <= '0;
      k_q       <= '0;
      zero_q    <= 1'b0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      shift_q   <= shift_d;
      k_q       <= k_d;
      zero_q    <= zero_d;
      in_rdy_q  <= in_rdy_d;
      out_vld_q <= out_vld_d;
    end
  end

`ifdef BSN_B2B_EN
  assign in_rdy_o = in_rdy_q | ((state_q == DONE) & out_rdy_i);
`else
  assign in_rdy_o = in_rdy_q;
`endif
  assign out_vld_o = out_vld_q;
  assign y_o       = y_q;
  assign shift_o   = shift_q;
  assign zero_o    = zero_q;

endmodule

// File: doc/bsn.md
Name: bsn

Overview:
- Sequential barrel-shift normalizer; the inverse of the shared barrel shifter.
- The shifter maps (x, shift) to y. This block takes x and returns the normalized value plus the shift amount that produces it.
- Left mode counts leading zeros; right mode counts trailing zeros.
- Uses a log-step binary search, one stage per cycle, behind valid/ready handshakes. Serves FP normalization and priority-encode paths.

Parameters:
- W, 32: data width; power of two, >= 2 (elaboration assertion).
- P_RIGHT, 1'b0: 0 = normalize toward MSB (leading zeros); 1 = normalize toward LSB (trailing zeros).
- SHIFT_W, $clog2(W): width of the shift count.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_vld_i  input  1  input command valid
- in_rdy_o  output  1  block can accept a command
- x_i  input  W  value to normalize
- out_vld_o  output  1  result valid
- out_rdy_i  input  1  consumer accepts result
- y_o  output  W  normalized value
- shift_o  output  SHIFT_W  shift amount applied
- zero_o  output  1  x_i was all zeros

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, in_rdy_o=1, out_vld_o=0, y_o=0, shift_o=0, zero_o=0, step counter=0.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - in_rdy_o=1.
  - On in_vld_i && in_rdy_o at edge T: load x_i into the working register, clear shift, set k=SHIFT_W-1, go to BUSY.
- BUSY:
  - in_rdy_o=0, out_vld_o=0. One stage per edge, k = SHIFT_W-1 down to 0.
  - Left mode: if the top 2^k bits of the working register are zero, shift it left by 2^k and set shift[k]=1.
  - Right mode: same test on the bottom 2^k bits, shifting right by 2^k.
  - At k=0: go to DONE and set zero_o = (working result == 0).
- Latency: out_vld_o rises after edge T+SHIFT_W (5 cycles for W=32). Latency is fixed and data-independent.
- DONE:
  - out_vld_o=1. y_o, shift_o and zero_o are held stable until out_rdy_i.
  - On out_vld_o && out_rdy_i: go to IDLE.
  - After the pop, outputs hold their last value (don't-care to the consumer).
- Invariants (when zero_o=0):
  - Left mode: y_o == x_i << shift_o and y_o[W-1]=1.
  - Right mode: y_o == x_i >> shift_o (logical) and y_o[0]=1.
- Zero input: y_o=0, shift_o=W-1 (all ones), zero_o=1. This falls out of the search naturally; no special case.
- Protocol:
  - in_vld_i may be held without acceptance.
  - x_i is sampled only on handshake.
  - out_vld_o never drops without out_rdy_i.
- Reset mid-operation (BUSY or DONE): the in-flight operation is discarded with no output. Next cycle the block is in IDLE with reset values.
- No combinational path from inputs to outputs, except as defined under Optional Feature.

Optional Feature:
- Macro: BSN_B2B_EN.
- Defined:
  - In DONE, in_rdy_o = out_rdy_i (combinational).
  - A simultaneous output pop and input accept goes DONE to BUSY directly.
  - Sustained throughput is one result per SHIFT_W+1 cycles.
- Undefined:
  - in_rdy_o is high only in IDLE and is purely registered.
  - One idle cycle is inserted between results.

Decomposition:
- Package bsn_pkg:
  - state enum (IDLE/BUSY/DONE).
  - function computing the 2^k stage mask for a given W, k and direction.
- Sub-module bsn_step: combinational single stage.
  - Inputs: working value, k.
  - Outputs: next value, hit bit.
  - Instanced once and reused each cycle with a muxed k.

Test Plan:
- W=32, left: x=0x0000_0001 -> y=0x8000_0000, shift=31, zero=0; out_vld_o exactly 5 cycles after accept.
- Left, x=0x8000_0000 -> y=0x8000_0000, shift=0; x=0x0001_2345 -> y=0x91A2_8000, shift=15.
- x=0 (both modes) -> y=0, shift=0x1F, zero=1. P_RIGHT=1: x=0x0000_0100 -> y=0x0000_0001, shift=8.
- Backpressure: out_rdy_i low 10 cycles while in_vld_i high with a new x -> y/shift/zero stable, in_rdy_o=0, new x accepted only after the pop.
- rst asserted during BUSY at k=2 -> next cycle in_rdy_o=1, out_vld_o=0, y_o=0, shift_o=0; a subsequent x=0x10 yields shift=27.
- BSN_B2B_EN: pop and push in the same cycle -> next result 5 cycles later, with no IDLE cycle; random 10k-op run against a reference model of the invariants.
